pdm_tx: RTL and testbench

PDM_TX -- requirements
Module: pdm_tx

---
 rtl/pdm_pkg.sv | 13 +
 rtl/sigma_delta_mod.sv | 29 ++
 rtl/pdm_tx.sv | 122 ++++++++++++
 tb/tb_pdm_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and state type for the PDM transmitter.
package pdm_pkg;

  localparam int SAMPLE_BITS = 7;
  localparam int WINDOW_BITS = 128;
  localparam int MIDSCALE    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_state_t;

endpackage

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta core: each step adds the sample into the accumulator
// and the carry out becomes the emitted PDM bit.
module sigma_delta_mod
  import pdm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic [SAMPLE_BITS-1:0] value,
  output logic                   pdm_bit
);

  logic [SAMPLE_BITS-1:0] acc;
  logic [SAMPLE_BITS:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, value};

  // acc is never cleared between samples so windows stay exact over time
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      pdm_bit <= 1'b0;
    end else if (step) begin
      acc     <= sum[SAMPLE_BITS-1:0];
      pdm_bit <= sum[SAMPLE_BITS];
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: m_clk divider, IDLE/RUN control and a two-entry sample
// buffer feeding the sigma-delta modulator.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int CLK_FREQ  = 100,
  parameter int M_CLK_DIV = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SAMPLE_BITS-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_clk,
  output logic                   m_data,
  output logic                   underflow,
  output logic                   busy
);

  localparam int DW = $clog2(M_CLK_DIV);
  localparam int BW = $clog2(WINDOW_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(M_CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(M_CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WINDOW_BITS - 1);

  if (M_CLK_DIV < 4 || (M_CLK_DIV % 2) != 0 || CLK_FREQ < 1) begin : g_param_check
    $error("pdm_tx: M_CLK_DIV must be even and >= 4");
  end

  pdm_state_t             state, state_nx;
  logic [DW-1:0]          div_cnt, div_nx;
  logic [BW-1:0]          bit_cnt, bit_nx;
  logic [SAMPLE_BITS-1:0] active, pending, mod_value;
  logic                   pending_full;
  logic                   m_clk_q, m_clk_nx;
  logic                   underflow_q;
  logic                   xfer, bit_edge, win_end, load_active;
  logic                   mod_bit;

  assign s_ready = !pending_full;
  assign xfer    = s_valid && s_ready;

  // Bit edges coincide with m_clk falling: RUN entry and every divider wrap.
  // Dropping enable turns the next bit edge into the return to IDLE.
  always_comb begin
    state_nx = state;
    div_nx   = '0;
    bit_edge = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pending_full) begin
          state_nx = RUN;
          bit_edge = 1'b1;
        end
      end
      RUN: begin
        if (div_cnt == DIV_LAST) begin
          if (enable) bit_edge = 1'b1;
          else        state_nx = IDLE;
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    win_end     = bit_edge && (state == RUN) && (bit_cnt == BIT_LAST);
    load_active = (bit_edge && (state == IDLE)) || (win_end && pending_full);
    mod_value   = (state == IDLE) ? pending : active;
    m_clk_nx    = (state_nx == RUN) && (div_nx >= DIV_HALF);
    if (state_nx == IDLE) bit_nx = '0;
    else if (bit_edge)    bit_nx = bit_cnt + BW'(1);
    else                  bit_nx = bit_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      m_clk_q <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      m_clk_q <= m_clk_nx;
    end
  end

  // A window that ends with nothing queued falls back to midscale (silence)
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (load_active)  active <= pending;
      else if (win_end) active <= SAMPLE_BITS'(MIDSCALE);
      if (xfer) pending <= s_data;
      pending_full <= (pending_full && !load_active) || xfer;
      if (win_end && !pending_full) underflow_q <= 1'b1;
    end
  end

  sigma_delta_mod u_mod (
    .clk     (clk),
    .rst     (rst),
    .step    (bit_edge),
    .value   (mod_value),
    .pdm_bit (mod_bit)
  );

  assign busy      = (state == RUN);
  assign m_clk     = m_clk_q;
  assign m_data    = mod_bit && busy;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Scoreboarded bench for pdm_tx: accepted samples expand into expected
// bitstreams; a monitor checks every m_clk rising-edge sample.
module tb_pdm_tx;

  localparam int DIV  = 40;
  localparam int HALF = DIV / 2;
  localparam int WIN  = 128;

  logic       clk = 1'b0;
  logic       rst, enable, s_valid;
  logic [6:0] s_data;
  logic       s_ready, m_clk, m_data, underflow, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int acc_m = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  pdm_tx #(.CLK_FREQ(100), .M_CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_clk     (m_clk),
    .m_data    (m_data),
    .underflow (underflow),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one window is 128 steps of a running sum; a bit is 1 whenever
  // the sum crosses 128, so a constant input yields exactly that many ones.
  task automatic push_window(input int v);
    for (int i = 0; i < WIN; i++) begin
      acc_m += v;
      exp_q.push_back(acc_m >= WIN);
      acc_m %= WIN;
    end
  endtask

  task automatic send(input int v, input int bound);
    int n;
    n = 0;
    while (!s_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", s_ready, 1);
    s_valid = 1'b1;
    s_data  = 7'(v);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_q(input int target, input int bound);
    int n;
    n = 0;
    while (exp_q.size() > target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain", int'(exp_q.size() <= target), 1);
  endtask

  // Monitor: bit checks on m_clk rise, plus period and first-rise latency
  initial begin
    int  since;
    bit  rise_ok, from_entry;
    logic mclk_q, busy_q;
    since = 0; rise_ok = 0; from_entry = 0; mclk_q = 0; busy_q = 0;
    forever begin
      @(negedge clk);
      since++;
      if (busy && !busy_q) begin
        since = 0; from_entry = 1; rise_ok = 1;
      end
      if (!busy) rise_ok = 0;
      if (m_clk && !mclk_q) begin
        rises++;
        if (rise_ok) begin
          if (from_entry) check("first_rise_latency", since, HALF);
          else            check("mclk_period", since, DIV);
        end
        from_entry = 0; rise_ok = busy; since = 0;
        if (exp_q.size() > 0) check("pdm_bit", int'(m_data), int'(exp_q.pop_front()));
      end
      mclk_q = m_clk;
      busy_q = busy;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[7];
    int n, highs, r0, v;
    logic prev;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_m_clk", m_clk, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_underflow", underflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    enable = 1'b1;

    vals[0] = 0; vals[1] = 32; vals[2] = 127; vals[3] = 64;
    vals[4] = int'($urandom_range(127, 0));
    vals[5] = int'($urandom_range(127, 0));
    vals[6] = 100;
    for (int i = 0; i < 7; i++) begin
      send(vals[i], 6000);
      push_window(vals[i]);
      if (i == 1) check("ready_low_after_pair", s_ready, 0);
    end
    // Nothing follows 100: its window must end in an underflow at midscale
    push_window(64);
    n = 0;
    while (!s_ready && n < 6000) begin @(negedge clk); n++; end
    check("ready_after_last_load", s_ready, 1);
    check("no_underflow_yet", underflow, 0);
    wait_q(WIN - 1, 6000);
    check("underflow_set", underflow, 1);
    wait_q(0, 6000);
    check("underflow_sticky", underflow, 1);

    // Drop enable mid-window: high phase finishes, then m_clk stays low
    r0 = rises;
    n = 0;
    while (rises < r0 + 50 && n < 3000) begin @(negedge clk); n++; end
    check("rises_before_drop", int'(rises >= r0 + 50), 1);
    enable = 1'b0;
    n = 0; prev = m_clk;
    while (busy && n < 60) begin prev = m_clk; @(negedge clk); n++; end
    check("busy_fall_within_40", int'(n <= DIV), 1);
    check("mclk_high_before_idle", prev, 1);
    check("mclk_low_at_idle", m_clk, 0);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      highs += int'(m_clk) + int'(m_data) + int'(busy);
    end
    check("idle_quiet", highs, 0);

    // Re-enter, then reset mid-window
    enable = 1'b1;
    send(20, 10);
    repeat (1000) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_m_clk", m_clk, 0);
    check("rstmid_m_data", m_data, 0);
    check("rstmid_s_ready", s_ready, 1);
    check("rstmid_underflow", underflow, 0);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    enable = 1'b0;
    acc_m = 0;
    exp_q.delete();
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      highs += int'(m_clk);
    end
    check("no_mclk_after_rst", highs, 0);

    // One fresh window after reset: accumulator must restart from zero
    enable = 1'b1;
    v = int'($urandom_range(127, 1));
    send(v, 10);
    push_window(v);
    wait_q(0, 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
